// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared types and default memory map for the MMIO bus decoder
//
// Purpose: FSM state type, default four-device region table, alias region
// for the split data memory, and the helper that packs per-device
// addresses into the flat vectors the decoder takes as parameters.
package mmio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ACCESS,
    S_RESP,
    S_ERR
  } state_t;

  // Device 0 lands in the lowest slice.
  function automatic logic [4*32-1:0] pack4(input logic [31:0] d0,
                                            input logic [31:0] d1,
                                            input logic [31:0] d2,
                                            input logic [31:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  // Device order: 0 = data RAM, 1 = program ROM, 2 = GPIO, 3 = UART.
  localparam logic [4*32-1:0] DEF_BASE  = pack4(32'h1001_0000, 32'h0040_0000,
                                                32'h1001_0024, 32'h1001_002C);
  localparam logic [4*32-1:0] DEF_LIMIT = pack4(32'h1001_0023, 32'h0FFF_FFFF,
                                                32'h1001_002B, 32'h1001_003B);

  // Upper part of data RAM, above the GPIO/UART hole. It selects device 0,
  // so data RAM offsets stay contiguous relative to its primary base.
  localparam logic [31:0] DEF_ALIAS_BASE  = 32'h1001_003C;
  localparam logic [31:0] DEF_ALIAS_LIMIT = 32'h7FFF_FFFF;

endpackage

// File: rtl/mmio_bus_decoder_if.sv
// rtl/mmio_bus_decoder_if.sv - uP-side and device-side bus bundle of the MMIO decoder
//
// Purpose: groups the uP load/store port and the device ports.
// slave  : the decoder's view (uP strobes, device read data/acks in).
// master : the surrounding system's view (uP and devices).
interface mmio_bus_decoder_if #(
  parameter int N_DEV  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                    MemRead;
  logic                    MemWrite;
  logic [ADDR_W-1:0]       AddrIn;
  logic [DATA_W-1:0]       DataIn;
  logic [DATA_W-1:0]       DataOut;
  logic                    Ready;
  logic                    BusErr;
  logic [ADDR_W-1:0]       ErrAddr;
  logic [N_DEV-1:0]        DevSel;
  logic [N_DEV-1:0]        DevWrite;
  logic [ADDR_W-1:0]       DevAddr;
  logic [DATA_W-1:0]       DevWData;
  logic [N_DEV*DATA_W-1:0] DevRData;
  logic [N_DEV-1:0]        DevAck;

  modport slave (
    input  MemRead, MemWrite, AddrIn, DataIn, DevRData, DevAck,
    output DataOut, Ready, BusErr, ErrAddr, DevSel, DevWrite, DevAddr, DevWData
  );

  modport master (
    output MemRead, MemWrite, AddrIn, DataIn, DevRData, DevAck,
    input  DataOut, Ready, BusErr, ErrAddr, DevSel, DevWrite, DevAddr, DevWData
  );
endinterface

// File: rtl/mmio_region_match.sv
// rtl/mmio_region_match.sv - combinational compare of one address against one region
//
// Purpose: hit when base <= addr <= limit (unsigned, full width); offset is
// the word offset (addr - base) >> 2 computed at ADDR_W bits.
// Ports: addr, base, limit in; hit, offset out.
module mmio_region_match #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] limit,
  output logic              hit,
  output logic [ADDR_W-1:0] offset
);

  assign hit    = (addr >= base) && (addr <= limit);
  assign offset = (addr - base) >> 2;

endmodule

// File: rtl/mmio_bus_decoder.sv
// rtl/mmio_bus_decoder.sv - sequential memory-map decoder with wait states and bus errors
//
// Purpose: latches a uP load/store, decodes it against the region table,
// drives a one-hot select with a word offset, waits for the device ack
// (bounded by TIMEOUT) and returns Ready or BusErr as one-cycle pulses.
// Ports: clk, rst (async, active high); bus (slave modport) carrying the
// uP strobes/address/data, DataOut/Ready/BusErr/ErrAddr, and the device
// select/write/address/data/ack signals.
module mmio_bus_decoder
  import mmio_pkg::*;
#(
  parameter int                      N_DEV       = 4,
  parameter int                      ADDR_W      = 32,
  parameter int                      DATA_W      = 32,
  parameter logic [N_DEV*ADDR_W-1:0] BASE_VEC    = mmio_pkg::DEF_BASE,
  parameter logic [N_DEV*ADDR_W-1:0] LIMIT_VEC   = mmio_pkg::DEF_LIMIT,
  parameter logic [N_DEV-1:0]        RO_MASK     = 4'b0010,
  parameter int                      TIMEOUT     = 15,
  parameter bit                      ALIAS_EN    = 1'b1,
  parameter int                      ALIAS_DEV   = 0,
  parameter logic [ADDR_W-1:0]       ALIAS_BASE  = mmio_pkg::DEF_ALIAS_BASE,
  parameter logic [ADDR_W-1:0]       ALIAS_LIMIT = mmio_pkg::DEF_ALIAS_LIMIT
) (
  input logic               clk,
  input logic               rst,
  mmio_bus_decoder_if.slave bus
);

  localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              conflict_q;
  logic [IDX_W-1:0]  sel_idx_q;
  logic [CNT_W-1:0]  wait_cnt;

  logic              strobe;
  logic [N_DEV-1:0]  hit;
  logic [ADDR_W-1:0] offset   [N_DEV];
  logic [DATA_W-1:0] rdata_arr[N_DEV];
  logic              alias_hit;
  logic              hit_any;
  logic [IDX_W-1:0]  hit_idx;
  logic              dec_err;
  logic              ack;
  logic              expired;

  assign strobe    = bus.MemRead | bus.MemWrite;
  assign alias_hit = ALIAS_EN && (addr_q >= ALIAS_BASE) && (addr_q <= ALIAS_LIMIT);

  for (genvar g = 0; g < N_DEV; g++) begin : g_region
    logic region_hit;

    mmio_region_match #(.ADDR_W(ADDR_W)) u_match (
      .addr  (addr_q),
      .base  (BASE_VEC[g*ADDR_W +: ADDR_W]),
      .limit (LIMIT_VEC[g*ADDR_W +: ADDR_W]),
      .hit   (region_hit),
      .offset(offset[g])
    );

    // A device with a second region: both regions raise the same select.
    assign hit[g]       = region_hit | ((ALIAS_DEV == g) ? alias_hit : 1'b0);
    assign rdata_arr[g] = bus.DevRData[g*DATA_W +: DATA_W];
  end

  // Lowest matching index wins: scan downwards so lower indices overwrite.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign dec_err = !hit_any || (addr_q[1:0] != 2'b00) || conflict_q ||
                   (wr_q && RO_MASK[hit_idx]);

  // Only the selected device's ack counts; on the last allowed cycle an
  // ack still takes priority over the timeout.
  assign ack     = bus.DevAck[sel_idx_q];
  assign expired = (wait_cnt >= CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (strobe) state_nx = S_DECODE;
      S_DECODE: state_nx = dec_err ? S_ERR : S_ACCESS;
      S_ACCESS: begin
        if (ack)          state_nx = S_RESP;
        else if (expired) state_nx = S_ERR;
      end
      S_RESP:   state_nx = S_IDLE;
      S_ERR:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs depend only on registers, so selects drop as soon as reset
  // or the state leaves ACCESS.
  always_comb begin
    bus.Ready    = (state == S_RESP);
    bus.BusErr   = (state == S_ERR);
    bus.DevSel   = '0;
    bus.DevWrite = '0;
    if (state == S_ACCESS) begin
      bus.DevSel[sel_idx_q]   = 1'b1;
      bus.DevWrite[sel_idx_q] = wr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      conflict_q   <= 1'b0;
      sel_idx_q    <= '0;
      wait_cnt     <= '0;
      bus.DevAddr  <= '0;
      bus.DevWData <= '0;
      bus.DataOut  <= '0;
      bus.ErrAddr  <= '0;
    end else begin
      if (state == S_IDLE && strobe) begin
        addr_q     <= bus.AddrIn;
        wdata_q    <= bus.DataIn;
        wr_q       <= bus.MemWrite;
        conflict_q <= bus.MemRead & bus.MemWrite;
      end

      if (state == S_DECODE && !dec_err) begin
        sel_idx_q    <= hit_idx;
        bus.DevAddr  <= offset[hit_idx];
        bus.DevWData <= wdata_q;
      end

      // Saturating wait counter, cleared whenever not in ACCESS.
      if (state == S_ACCESS) begin
        if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (state == S_ACCESS && ack && !wr_q) bus.DataOut <= rdata_arr[sel_idx_q];

      if (state_nx == S_ERR) bus.ErrAddr <= addr_q;
    end
  end

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// tb/tb_mmio_bus_decoder.sv - directed vector bench for mmio_bus_decoder
module tb_mmio_bus_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mmio_bus_decoder_if #(.N_DEV(4), .ADDR_W(32), .DATA_W(32)) bus_if ();

  mmio_bus_decoder #(.N_DEV(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_dev;
    int          ack_delay;   // ack-free ACCESS cycles before the ack, -1 = never
    logic [31:0] rdata;
    logic [3:0]  noise;       // acks raised by non-selected devices
    bit          exp_ready;
    bit          exp_err;
    int          exp_lat;
    int          exp_acc;
    logic [3:0]  exp_sel;
    logic [31:0] exp_daddr;
    logic [31:0] exp_dout;
    logic [31:0] exp_eaddr;
  } vec_t;

  function automatic vec_t mk(bit rd, bit wr, logic [31:0] addr, logic [31:0] wdata,
                              int ack_dev, int ack_delay, logic [31:0] rdata,
                              logic [3:0] noise, bit exp_ready, bit exp_err,
                              int exp_lat, int exp_acc, logic [3:0] exp_sel,
                              logic [31:0] exp_daddr, logic [31:0] exp_dout,
                              logic [31:0] exp_eaddr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.ack_dev = ack_dev; v.ack_delay = ack_delay; v.rdata = rdata; v.noise = noise;
    v.exp_ready = exp_ready; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_acc = exp_acc;
    v.exp_sel = exp_sel; v.exp_daddr = exp_daddr; v.exp_dout = exp_dout; v.exp_eaddr = exp_eaddr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int          acc;
    int          lat;
    bit          done;
    bit          got_r;
    bit          got_e;
    bit          stable;
    logic [3:0]  first_sel;
    logic [31:0] first_daddr;
    logic [31:0] first_wdata;
    acc = 0; lat = 0; done = 1'b0; got_r = 1'b0; got_e = 1'b0; stable = 1'b1;
    first_sel = '0; first_daddr = '0; first_wdata = '0;
    for (int j = 0; j < 4; j++)
      bus_if.DevRData[j*32 +: 32] = (j == v.ack_dev) ? v.rdata : (v.rdata ^ 32'hFFFF_0000 ^ 32'(j));
    bus_if.MemRead  = v.rd;
    bus_if.MemWrite = v.wr;
    bus_if.AddrIn   = v.addr;
    bus_if.DataIn   = v.wdata;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      bus_if.DevAck = '0;
      if (bus_if.Ready || bus_if.BusErr) begin
        got_r = bus_if.Ready;
        got_e = bus_if.BusErr;
        lat   = cyc;
        done  = 1'b1;
        bus_if.MemRead  = 1'b0;
        bus_if.MemWrite = 1'b0;
      end else if (bus_if.DevSel != 4'b0000) begin
        acc++;
        if (acc == 1) begin
          first_sel   = bus_if.DevSel;
          first_daddr = bus_if.DevAddr;
          first_wdata = bus_if.DevWData;
        end else if (bus_if.DevSel != first_sel || bus_if.DevAddr != first_daddr ||
                     bus_if.DevWData != first_wdata) begin
          stable = 1'b0;
        end
        if (bus_if.DevWrite != (v.wr ? first_sel : 4'b0000)) stable = 1'b0;
        bus_if.DevAck = v.noise & ~bus_if.DevSel;
        if (v.ack_delay >= 0 && acc - 1 == v.ack_delay)
          bus_if.DevAck = bus_if.DevAck | (4'b0001 << v.ack_dev);
      end
    end
    if (!done) chk({nm, " completion"}, 64'd0, 64'd1);
    chk({nm, " ready"},   64'(got_r), 64'(v.exp_ready));
    chk({nm, " buserr"},  64'(got_e), 64'(v.exp_err));
    chk({nm, " latency"}, 64'(lat), 64'(v.exp_lat));
    chk({nm, " sel_cycles"}, 64'(acc), 64'(v.exp_acc));
    chk({nm, " devsel"},  64'(first_sel), 64'(v.exp_sel));
    if (v.exp_acc > 0) begin
      chk({nm, " devaddr"},  64'(first_daddr), 64'(v.exp_daddr));
      chk({nm, " devwdata"}, 64'(first_wdata), 64'(v.wdata));
      chk({nm, " stable"},   64'(stable), 64'd1);
    end
    chk({nm, " dataout"}, 64'(bus_if.DataOut), 64'(v.exp_dout));
    if (v.exp_err) chk({nm, " erraddr"}, 64'(bus_if.ErrAddr), 64'(v.exp_eaddr));
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.MemRead  = 1'b0;
    bus_if.MemWrite = 1'b0;
    bus_if.AddrIn   = '0;
    bus_if.DataIn   = '0;
    bus_if.DevRData = '0;
    bus_if.DevAck   = '0;

    //            rd wr addr          wdata         dev dly rdata         noise  rdy err lat acc sel      daddr         dout          eaddr
    vecs[0]  = mk(1, 0, 32'h0040_0008, 32'h0,        1,  0, 32'hDEAD_BEEF, 4'h0, 1, 0,  3,  1, 4'b0010, 32'h2,        32'hDEAD_BEEF, 32'h0);
    vecs[1]  = mk(0, 1, 32'h1001_0024, 32'h55,       2,  4, 32'h1111_1111, 4'h8, 1, 0,  7,  5, 4'b0100, 32'h0,        32'hDEAD_BEEF, 32'h0);
    vecs[2]  = mk(1, 0, 32'h0000_1000, 32'h0,        0, -1, 32'h0,         4'h0, 0, 1,  2,  0, 4'b0000, 32'h0,        32'hDEAD_BEEF, 32'h0000_1000);
    vecs[3]  = mk(0, 1, 32'h0040_0000, 32'h77,       1,  0, 32'h0,         4'h0, 0, 1,  2,  0, 4'b0000, 32'h0,        32'hDEAD_BEEF, 32'h0040_0000);
    vecs[4]  = mk(1, 0, 32'h1001_0002, 32'h0,        0,  0, 32'h0,         4'h0, 0, 1,  2,  0, 4'b0000, 32'h0,        32'hDEAD_BEEF, 32'h1001_0002);
    vecs[5]  = mk(1, 0, 32'h1001_002C, 32'h0,        3, -1, 32'h0,         4'h0, 0, 1, 17, 15, 4'b1000, 32'h0,        32'hDEAD_BEEF, 32'h1001_002C);
    vecs[6]  = mk(1, 0, 32'h1001_0030, 32'h0,        3, 14, 32'h1234_5678, 4'h0, 1, 0, 17, 15, 4'b1000, 32'h1,        32'h1234_5678, 32'h0);
    vecs[7]  = mk(1, 0, 32'h1001_0040, 32'h0,        0,  1, 32'hA5A5_0001, 4'h0, 1, 0,  4,  2, 4'b0001, 32'h10,       32'hA5A5_0001, 32'h0);
    vecs[8]  = mk(1, 1, 32'h1001_0000, 32'h99,       0,  0, 32'h0,         4'h0, 0, 1,  2,  0, 4'b0000, 32'h0,        32'hA5A5_0001, 32'h1001_0000);
    vecs[9]  = mk(0, 1, 32'h1001_0020, 32'hCAFE,     0,  0, 32'h2222_2222, 4'h0, 1, 0,  3,  1, 4'b0001, 32'h8,        32'hA5A5_0001, 32'h0);
    vecs[10] = mk(1, 0, 32'h0FFF_FFFC, 32'h0,        1,  0, 32'h0BAD_F00D, 4'h0, 1, 0,  3,  1, 4'b0010, 32'h03EF_FFFF, 32'h0BAD_F00D, 32'h0);
    vecs[11] = mk(1, 0, 32'h1001_003C, 32'h0,        0,  0, 32'h3C3C_3C3C, 4'h0, 1, 0,  3,  1, 4'b0001, 32'hF,        32'h3C3C_3C3C, 32'h0);
    vecs[12] = mk(1, 0, 32'h8000_0000, 32'h0,        0,  0, 32'h0,         4'h0, 0, 1,  2,  0, 4'b0000, 32'h0,        32'h3C3C_3C3C, 32'h8000_0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset devsel",   64'(bus_if.DevSel), 64'd0);
    chk("reset devwrite", 64'(bus_if.DevWrite), 64'd0);
    chk("reset ready",    64'(bus_if.Ready), 64'd0);
    chk("reset buserr",   64'(bus_if.BusErr), 64'd0);
    chk("reset dataout",  64'(bus_if.DataOut), 64'd0);
    chk("reset erraddr",  64'(bus_if.ErrAddr), 64'd0);
    chk("reset devaddr",  64'(bus_if.DevAddr), 64'd0);
    rst = 1'b0;

    for (int k = 0; k < 13; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Reset in the middle of an ACCESS wait on the never-acking UART.
    bus_if.MemRead = 1'b1;
    bus_if.AddrIn  = 32'h1001_002C;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("midrst sel_before", 64'(bus_if.DevSel), 64'b1000);
    rst = 1'b1;
    #1;
    chk("midrst sel_now",    64'(bus_if.DevSel), 64'd0);
    chk("midrst ready_now",  64'(bus_if.Ready), 64'd0);
    chk("midrst err_now",    64'(bus_if.BusErr), 64'd0);
    chk("midrst dataout",    64'(bus_if.DataOut), 64'd0);
    bus_if.MemRead = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst quiet", 64'({bus_if.Ready, bus_if.BusErr, bus_if.DevSel}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("postrst quiet", 64'({bus_if.Ready, bus_if.BusErr, bus_if.DevSel}), 64'd0);
    run_vec(mk(1, 0, 32'h0040_0004, 32'h0, 1, 0, 32'h600D_600D, 4'h0, 1, 0, 3, 1,
               4'b0010, 32'h1, 32'h600D_600D, 32'h0), "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
